fetch_unit: RTL and testbench

//  Instruction fetch front end. Owns the PC, issues requests to the icache, and drives the branch

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_branch_decode.sv | 33 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch front end: opcodes, FSM states, immediate decode.
package fetch_unit_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // B-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // J-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_branch_decode.sv
// Combinational static decode of JAL/branch combined with the predictor jump bit.
module fetch_branch_decode
    import fetch_unit_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        pred_jump,
    output logic        pred_taken,
    output logic [31:0] pred_pc
);

    // Pick the predicted next PC; anything not JAL/branch falls through to pc+4
    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = pc + 32'd4;
        case (instr[6:0])
            OPC_JAL: begin
                pred_taken = 1'b1;
                pred_pc    = pc + imm_j(instr);
            end
            OPC_BRANCH: begin
                pred_taken = pred_jump;
                if (pred_jump) begin
                    pred_pc = pc + imm_b(instr);
                end
            end
            // Register-indirect target is unknown here; the ROB redirects if wrong
            OPC_JALR: pred_taken = 1'b0;
            default:  pred_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, icache request FSM, IQ push with one-entry hold.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clockIn,
    input  logic        resetIn,
    output logic        icacheReqValid,
    output logic [31:0] icacheAddr,
    input  logic        icacheHit,
    input  logic [31:0] icacheInstr,
    output logic [31:0] predAddr,
    input  logic        predJump,
    input  logic        iqFull,
    output logic        iqValid,
    output logic [31:0] iqInstr,
    output logic [31:0] iqPC,
    output logic        iqPredTaken,
    output logic [31:0] iqPredPC,
    input  logic        redirectValid,
    input  logic [31:0] redirectPC
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  held_instr;
    logic [31:0]  held_pred_pc;
    logic         held_taken;
    logic         dec_taken;
    logic [31:0]  dec_pc;

    assign icacheAddr = pc;
    assign predAddr   = pc;

    fetch_branch_decode u_decode (
        .instr      (icacheInstr),
        .pc         (pc),
        .pred_jump  (predJump),
        .pred_taken (dec_taken),
        .pred_pc    (dec_pc)
    );

    // Fetch FSM: redirect first, then push on hit or park the entry while the IQ is full
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            icacheReqValid <= 1'b0;
            iqValid        <= 1'b0;
            iqInstr        <= '0;
            iqPC           <= '0;
            iqPredTaken    <= 1'b0;
            iqPredPC       <= '0;
            held_instr     <= '0;
            held_pred_pc   <= '0;
            held_taken     <= 1'b0;
        end else begin
            iqValid <= 1'b0;
            if (redirectValid) begin
                pc             <= redirectPC;
                state          <= FETCH;
                icacheReqValid <= 1'b0;
            end else begin
                case (state)
                    FETCH: begin
                        state          <= WAIT;
                        icacheReqValid <= 1'b1;
                    end
                    WAIT: begin
                        if (icacheHit && !iqFull) begin
                            iqValid        <= 1'b1;
                            iqInstr        <= icacheInstr;
                            iqPC           <= pc;
                            iqPredTaken    <= dec_taken;
                            iqPredPC       <= dec_pc;
                            pc             <= dec_pc;
                            state          <= FETCH;
                            icacheReqValid <= 1'b1;
                        end else if (icacheHit) begin
                            held_instr     <= icacheInstr;
                            held_taken     <= dec_taken;
                            held_pred_pc   <= dec_pc;
                            state          <= HOLD;
                            icacheReqValid <= 1'b0;
                        end else begin
                            icacheReqValid <= 1'b1;
                        end
                    end
                    HOLD: begin
                        // pc still addresses the held instruction, so it doubles as its PC
                        if (!iqFull) begin
                            iqValid        <= 1'b1;
                            iqInstr        <= held_instr;
                            iqPC           <= pc;
                            iqPredTaken    <= held_taken;
                            iqPredPC       <= held_pred_pc;
                            pc             <= held_pred_pc;
                            state          <= FETCH;
                            icacheReqValid <= 1'b1;
                        end
                    end
                    default: begin
                        state          <= FETCH;
                        icacheReqValid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reference model plus directed vectors.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clockIn = 1'b0;
    logic        resetIn = 1'b0;
    logic        icacheReqValid;
    logic [31:0] icacheAddr;
    logic        icacheHit = 1'b0;
    logic [31:0] icacheInstr = '0;
    logic [31:0] predAddr;
    logic        predJump = 1'b0;
    logic        iqFull = 1'b0;
    logic        iqValid;
    logic [31:0] iqInstr;
    logic [31:0] iqPC;
    logic        iqPredTaken;
    logic [31:0] iqPredPC;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPC = '0;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clockIn        (clockIn),
        .resetIn        (resetIn),
        .icacheReqValid (icacheReqValid),
        .icacheAddr     (icacheAddr),
        .icacheHit      (icacheHit),
        .icacheInstr    (icacheInstr),
        .predAddr       (predAddr),
        .predJump       (predJump),
        .iqFull         (iqFull),
        .iqValid        (iqValid),
        .iqInstr        (iqInstr),
        .iqPC           (iqPC),
        .iqPredTaken    (iqPredTaken),
        .iqPredPC       (iqPredPC),
        .redirectValid  (redirectValid),
        .redirectPC     (redirectPC)
    );

    always #5 clockIn = ~clockIn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc = RESET_PC;
    bit          m_req, m_wait, m_held, m_iqv, m_pt, h_pt;
    logic [31:0] m_instr, m_ipc, m_ppc, h_instr, h_ppc;

    // Next-PC rule from the ISA encodings, using signed integer offsets
    function automatic logic [31:0] model_next(input logic [31:0] instr, input logic [31:0] pc,
                                               input bit pj, output bit taken);
        int off;
        taken = 1'b0;
        model_next = pc + 32'd4;
        if (instr[6:0] == 7'h6F) begin
            off = int'(instr[30:21]) * 2 + int'(instr[20]) * 2048 + int'(instr[19:12]) * 4096
                  - (instr[31] ? 1048576 : 0);
            taken = 1'b1;
            model_next = pc + unsigned'(off);
        end else if (instr[6:0] == 7'h63 && pj) begin
            off = int'(instr[11:8]) * 2 + int'(instr[30:25]) * 32 + int'(instr[7]) * 2048
                  - (instr[31] ? 4096 : 0);
            taken = 1'b1;
            model_next = pc + unsigned'(off);
        end
    endfunction

    always @(posedge clockIn or negedge resetIn) begin
        bit          t;
        logic [31:0] nxt;
        if (!resetIn) begin
            m_pc = RESET_PC; m_req = 0; m_wait = 0; m_held = 0; m_iqv = 0;
        end else begin
            m_iqv = 0;
            if (redirectValid) begin
                m_pc = redirectPC; m_held = 0; m_wait = 0; m_req = 0;
            end else if (m_held) begin
                if (!iqFull) begin
                    m_iqv = 1; m_instr = h_instr; m_ipc = m_pc; m_pt = h_pt; m_ppc = h_ppc;
                    m_pc = h_ppc; m_held = 0; m_req = 1;
                end
            end else if (m_wait) begin
                if (icacheHit) begin
                    nxt = model_next(icacheInstr, m_pc, predJump, t);
                    m_wait = 0;
                    if (!iqFull) begin
                        m_iqv = 1; m_instr = icacheInstr; m_ipc = m_pc; m_pt = t; m_ppc = nxt;
                        m_pc = nxt; m_req = 1;
                    end else begin
                        h_instr = icacheInstr; h_pt = t; h_ppc = nxt; m_held = 1; m_req = 0;
                    end
                end
            end else begin
                m_wait = 1; m_req = 1;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clockIn) begin
        check("req_valid", {31'b0, icacheReqValid}, {31'b0, m_req});
        check("icache_addr", icacheAddr, m_pc);
        check("pred_addr", predAddr, m_pc);
        check("iq_valid", {31'b0, iqValid}, {31'b0, m_iqv});
        if (m_iqv) begin
            check("iq_instr", iqInstr, m_instr);
            check("iq_pc", iqPC, m_ipc);
            check("iq_pred_taken", {31'b0, iqPredTaken}, {31'b0, m_pt});
            check("iq_pred_pc", iqPredPC, m_ppc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit hit, input logic [31:0] instr, input bit pj, input bit full,
                        input bit redir, input logic [31:0] rpc);
        icacheHit = hit; icacheInstr = instr; predJump = pj; iqFull = full;
        redirectValid = redir; redirectPC = rpc;
        @(negedge clockIn);
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0, '0);
    endtask

    task automatic hit_instr(input logic [31:0] instr, input bit pj);
        step(1, instr, pj, 0, 0, '0);
    endtask

    task automatic redirect(input logic [31:0] rpc);
        step(0, '0, 0, 0, 1, rpc);
    endtask

    logic [31:0] vec_instr [5] = '{32'hFF1FF06F, 32'h00000463, 32'h00000463, 32'h000080E7, 32'h8000006F};
    bit          vec_pj    [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        repeat (3) @(negedge clockIn);
        check("rst_iq_valid", {31'b0, iqValid}, 32'd0);
        check("rst_req_valid", {31'b0, icacheReqValid}, 32'd0);
        check("rst_iq_instr", iqInstr, 32'h0);
        check("rst_iq_pc", iqPC, 32'h0);
        check("rst_iq_pred_pc", iqPredPC, 32'h0);
        check("rst_iq_pred_taken", {31'b0, iqPredTaken}, 32'd0);
        check("rst_addr", icacheAddr, RESET_PC);
        resetIn = 1'b1;

        // Plain instruction at reset PC
        idle();
        check("t1_req", {31'b0, icacheReqValid}, 32'd1);
        hit_instr(32'h00000013, 0);
        check("t1_valid", {31'b0, iqValid}, 32'd1);
        check("t1_pc", iqPC, 32'h0);
        check("t1_taken", {31'b0, iqPredTaken}, 32'd0);
        check("t1_ppc", iqPredPC, 32'h4);
        idle();
        check("t1_next_addr", icacheAddr, 32'h4);

        // JAL +16
        redirect(32'h100);
        check("t2_redir_req", {31'b0, icacheReqValid}, 32'd0);
        idle();
        hit_instr(32'h0100006F, 0);
        check("t2_taken", {31'b0, iqPredTaken}, 32'd1);
        check("t2_ppc", iqPredPC, 32'h110);
        idle();
        check("t2_next_addr", icacheAddr, 32'h110);

        // BEQ -8, predicted taken then not taken
        redirect(32'h200); idle();
        hit_instr(32'hFE000CE3, 1);
        check("t3a_taken", {31'b0, iqPredTaken}, 32'd1);
        check("t3a_ppc", iqPredPC, 32'h1F8);
        redirect(32'h200); idle();
        hit_instr(32'hFE000CE3, 0);
        check("t3b_taken", {31'b0, iqPredTaken}, 32'd0);
        check("t3b_ppc", iqPredPC, 32'h204);
        idle();

        // IQ full for three cycles
        step(1, 32'h00100093, 0, 1, 0, '0);
        for (int i = 0; i < 2; i++) begin
            check("t4_hold_valid", {31'b0, iqValid}, 32'd0);
            check("t4_hold_req", {31'b0, icacheReqValid}, 32'd0);
            step(0, '0, 0, 1, 0, '0);
        end
        check("t4_hold_valid_last", {31'b0, iqValid}, 32'd0);
        idle();
        check("t4_push_valid", {31'b0, iqValid}, 32'd1);
        check("t4_push_instr", iqInstr, 32'h00100093);
        check("t4_push_pc", iqPC, 32'h204);
        check("t4_push_ppc", iqPredPC, 32'h208);
        idle();
        check("t4_single_push", {31'b0, iqValid}, 32'd0);
        check("t4_next_addr", icacheAddr, 32'h208);

        // Redirect with coincident hit, then redirect out of HOLD
        step(1, 32'h00000013, 0, 0, 1, 32'h400);
        check("t5_drop_valid", {31'b0, iqValid}, 32'd0);
        check("t5_addr", icacheAddr, 32'h400);
        idle();
        step(1, 32'h0100006F, 0, 1, 0, '0);
        step(0, '0, 0, 1, 1, 32'h480);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t5_discard_valid", {31'b0, iqValid}, 32'd0);
        end
        check("t5_discard_addr", icacheAddr, 32'h480);

        // PC wrap at the top of the address space
        redirect(32'hFFFF_FFFC); idle();
        hit_instr(32'h00000013, 0);
        check("wrap_ppc", iqPredPC, 32'h0);
        idle();

        // Mixed decode cases with varying wait lengths, checked by the model
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 1) idle();
            hit_instr(vec_instr[i], vec_pj[i]);
            idle();
        end

        // Reset asserted during a push cycle
        hit_instr(32'h00000013, 0);
        #2 resetIn = 1'b0;
        #1;
        check("t6a_valid", {31'b0, iqValid}, 32'd0);
        check("t6a_req", {31'b0, icacheReqValid}, 32'd0);
        check("t6a_iq_pc", iqPC, 32'h0);
        @(negedge clockIn);
        resetIn = 1'b1;
        idle();
        check("t6a_addr", icacheAddr, RESET_PC);
        check("t6a_req_after", {31'b0, icacheReqValid}, 32'd1);

        // Reset asserted mid-WAIT
        redirect(32'h300); idle(); idle();
        #2 resetIn = 1'b0;
        #1;
        check("t6b_req", {31'b0, icacheReqValid}, 32'd0);
        check("t6b_addr", icacheAddr, RESET_PC);
        @(negedge clockIn);
        resetIn = 1'b1;
        idle();
        check("t6b_first_addr", icacheAddr, RESET_PC);
        hit_instr(32'h00000013, 0);
        check("t6b_first_push_pc", iqPC, RESET_PC);
        idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
